// File: rtl/li_fork_if.sv
// li_fork channel bundle: one upstream li channel, two downstream.
// Carries the optional accept counter so both builds share ports.
interface li_fork_if #(
  parameter int DWIDTH = 16
);
  logic [DWIDTH-1:0] i_data;
  logic              i_data_valid;
  logic              i_data_stop;
  logic [DWIDTH-1:0] o_data1;
  logic              o_data1_valid;
  logic              o_data1_stop;
  logic [DWIDTH-1:0] o_data2;
  logic              o_data2_valid;
  logic              o_data2_stop;
  logic [31:0]       o_accept_count;

  modport master (
    output i_data,
    output i_data_valid,
    input  i_data_stop,
    input  o_data1,
    input  o_data1_valid,
    output o_data1_stop,
    input  o_data2,
    input  o_data2_valid,
    output o_data2_stop,
    input  o_accept_count
  );

  modport slave (
    input  i_data,
    input  i_data_valid,
    output i_data_stop,
    output o_data1,
    output o_data1_valid,
    input  o_data1_stop,
    output o_data2,
    output o_data2_valid,
    input  o_data2_stop,
    output o_accept_count
  );
endinterface

// File: rtl/li_fork.sv
// Latency-insensitive fork: one li channel broadcast to two queued branches.
// Optional accept counter enabled by defining LI_FORK_STATS_EN.
module li_fork #(
  parameter int DWIDTH = 16,
  parameter int DEPTH  = 2
) (
  input logic     clk,
  input logic     reset,
  li_fork_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  function automatic logic [PW-1:0] inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  logic              acc;
  logic              stop_q;
  logic [1:0]        stp;
  logic [1:0]        vld;
  logic [1:0]        deq;
  logic [CW-1:0]     cnt_q [2];
  logic [CW-1:0]     cnt_n [2];
  logic [PW-1:0]     rp_q  [2];
  logic [PW-1:0]     rp_n  [2];
  logic [PW-1:0]     wp_q  [2];
  logic [DWIDTH-1:0] head_q [2];
  logic [DWIDTH-1:0] mem [2][DEPTH];

  assign acc = bus.i_data_valid && !stop_q;
  assign stp = {bus.o_data2_stop, bus.o_data1_stop};

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      vld[k]   = (cnt_q[k] != '0);
      deq[k]   = vld[k] && !stp[k];
      cnt_n[k] = cnt_q[k] + CW'(acc) - CW'(deq[k]);
      rp_n[k]  = deq[k] ? inc(rp_q[k]) : rp_q[k];
    end
  end

  // Storage is not reset; count and pointers define what is live.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (acc) mem[k][wp_q[k]] <= bus.i_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stop_q <= 1'b0;
      for (int k = 0; k < 2; k++) begin
        cnt_q[k]  <= '0;
        rp_q[k]   <= '0;
        wp_q[k]   <= '0;
        head_q[k] <= '0;
      end
    end else begin
      stop_q <= (cnt_n[0] == CW'(DEPTH))
             || (cnt_n[1] == CW'(DEPTH));
      for (int k = 0; k < 2; k++) begin
        cnt_q[k] <= cnt_n[k];
        rp_q[k]  <= rp_n[k];
        if (acc) wp_q[k] <= inc(wp_q[k]);
        // Head is registered; an emptying queue takes the new token.
        if (cnt_n[k] != '0) begin
          head_q[k] <= (cnt_q[k] == CW'(deq[k]))
                     ? bus.i_data
                     : mem[k][rp_n[k]];
        end
      end
    end
  end

  assign bus.i_data_stop   = stop_q;
  assign bus.o_data1       = head_q[0];
  assign bus.o_data1_valid = vld[0];
  assign bus.o_data2       = head_q[1];
  assign bus.o_data2_valid = vld[1];

`ifdef LI_FORK_STATS_EN
  logic [31:0] acc_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   acc_q <= '0;
    else if (acc) acc_q <= acc_q + 32'd1;
  end

  assign bus.o_accept_count = acc_q;
`else
  assign bus.o_accept_count = '0;
`endif
endmodule

// File: tb/tb_li_fork.sv
// Bench for li_fork: directed scenarios plus random traffic
// checked against a queue-based reference of the fork.
module tb_li_fork;
  localparam int DW = 16;
  localparam int DP = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad = 0;

  li_fork_if #(.DWIDTH(DW)) bus ();

  li_fork #(.DWIDTH(DW), .DEPTH(DP)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] q1 [$];
  logic [DW-1:0] q2 [$];
  logic [DW-1:0] src [$];
  logic [DW-1:0] last1 = '0;
  logic [DW-1:0] last2 = '0;
  logic          exp_stop = 1'b0;
  logic [31:0]   exp_acc = '0;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic check_outs();
    logic [31:0] ea;
`ifdef LI_FORK_STATS_EN
    ea = exp_acc;
`else
    ea = '0;
`endif
    check("stop", 32'(bus.i_data_stop), 32'(exp_stop));
    check("v1", 32'(bus.o_data1_valid),
          32'(q1.size() != 0));
    check("v2", 32'(bus.o_data2_valid),
          32'(q2.size() != 0));
    check("d1", 32'(bus.o_data1), 32'(last1));
    check("d2", 32'(bus.o_data2), 32'(last2));
    check("acc", bus.o_accept_count, ea);
  endtask

  // One cycle: check at negedge, drive, then advance the model.
  task automatic cycle(input bit v, input bit s1, input bit s2);
    logic a;
    logic p1;
    logic p2;
    check_outs();
    bus.i_data_valid = v && (src.size() != 0);
    bus.i_data = (src.size() != 0) ? src[0] : DW'($urandom);
    bus.o_data1_stop = s1;
    bus.o_data2_stop = s2;
    @(posedge clk);
    a  = bus.i_data_valid && !exp_stop;
    p1 = (q1.size() != 0) && !s1;
    p2 = (q2.size() != 0) && !s2;
    if (p1) void'(q1.pop_front());
    if (p2) void'(q2.pop_front());
    if (a) begin
      q1.push_back(src[0]);
      q2.push_back(src[0]);
      void'(src.pop_front());
      exp_acc++;
    end
    if (q1.size() != 0) last1 = q1[0];
    if (q2.size() != 0) last2 = q2[0];
    exp_stop = (q1.size() == DP) || (q2.size() == DP);
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 1'b0);
    check("drained", 32'(q1.size() + q2.size() + src.size()), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_data = '0;
    bus.i_data_valid = 1'b0;
    bus.o_data1_stop = 1'b0;
    bus.o_data2_stop = 1'b0;
    repeat (3) @(negedge clk);
    check_outs();
    reset = 1'b1;

    for (int i = 1; i <= 8; i++) src.push_back(DW'(i));
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 1'b0);
    check("stream_src", 32'(src.size()), 0);
    drain();

    for (int i = 0; i < 4; i++) src.push_back(DW'(16'hA000 + i));
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 1'b0);
    check("stall_src", 32'(src.size()), 2);
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 1'b0);
    drain();

    for (int i = 0; i < 20; i++) src.push_back(DW'($urandom));
    for (int i = 0; i < 60; i++) cycle(1'b1, i[0], !i[0]);
    drain();

    for (int i = 0; i < 4; i++) src.push_back(DW'(16'hB000 + i));
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b1);
    check("full_src", 32'(src.size()), 2);
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 1'b0);
    drain();

    for (int i = 0; i < 300; i++) begin
      if (src.size() < 3) src.push_back(DW'($urandom));
      cycle($urandom_range(0, 3) != 0,
            $urandom_range(0, 2) == 0,
            $urandom_range(0, 1) == 0);
    end
    src.delete();
    drain();

    src.push_back(16'h0011);
    src.push_back(16'h0022);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b1);
    check("pre_rst_v1", 32'(bus.o_data1_valid), 1);
    #2 reset = 1'b0;
    #1;
    check("rst_v1", 32'(bus.o_data1_valid), 0);
    check("rst_v2", 32'(bus.o_data2_valid), 0);
    check("rst_stop", 32'(bus.i_data_stop), 0);
    check("rst_d1", 32'(bus.o_data1), 0);
    check("rst_d2", 32'(bus.o_data2), 0);
    q1.delete();
    q2.delete();
    src.delete();
    last1 = '0;
    last2 = '0;
    exp_stop = 1'b0;
    exp_acc = '0;
    bus.o_data1_stop = 1'b0;
    bus.o_data2_stop = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    src.push_back(16'h0033);
    cycle(1'b1, 1'b0, 1'b0);
    check("post_d1", 32'(bus.o_data1), 32'h33);
    check("post_d2", 32'(bus.o_data2), 32'h33);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/li_fork.md
Name: li_fork

Overview:
- Latency-insensitive fork: one upstream li-style channel (data/valid/stop) is broadcast to two downstream channels. Each token is delivered exactly once on each output.
- Each branch has its own small queue, so one slow consumer does not stall the other until that branch's queue fills.
- Upstream stop is registered, so the block also acts as a relay station that breaks the combinational stop path.
- Used at the output of a pearl shell when one result feeds two consumers; it is the split counterpart of the two-into-one join the shells already perform.

Parameters:
- DWIDTH, 16, token data width in bits.
- DEPTH, 2, entries per branch queue; must be >= 2 for full throughput.

Ports:
- clk  input  1  clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- i_data  input  DWIDTH  upstream token data.
- i_data_valid  input  1  upstream token present.
- i_data_stop  output  1  registered back-pressure to upstream.
- o_data1  output  DWIDTH  branch 1 head data.
- o_data1_valid  output  1  branch 1 token present.
- o_data1_stop  input  1  branch 1 back-pressure.
- o_data2  output  DWIDTH  branch 2 head data.
- o_data2_valid  output  1  branch 2 token present.
- o_data2_stop  input  1  branch 2 back-pressure.
- o_accept_count  output  32  accepted-token counter; see Optional Feature.

Behaviour:
- Accept: upstream token consumed in cycle t iff i_data_valid && !i_data_stop. It is written into both branch queues at that edge.
- Dequeue: branch k dequeues iff o_datak_valid && !o_datak_stop. The two branches are fully independent.
- Queue k: circular buffer, DEPTH entries.
  - Read/write pointers wrap modulo DEPTH.
  - count_k is $clog2(DEPTH+1) bits.
  - count_k_next = count_k + enq - deq_k.
  - Simultaneous enq and deq keeps count unchanged, including at count = DEPTH-1 and at empty with a bypass-free write.
- Outputs:
  - o_datak_valid = (count_k != 0).
  - o_datak = entry at read pointer, driven from storage; no combinational path from i_data.
  - When invalid, o_datak holds its last value (0 after reset).
- Stop register: i_data_stop <= (count_1_next == DEPTH) || (count_2_next == DEPTH).
  - Guarantees room for any token accepted while stop=0, so no overflow is possible.
  - No combinational path from o_datak_stop or i_data_valid to i_data_stop.
- Latency: a token accepted at edge t appears valid on both outputs in cycle t+1.
- Throughput: one token/cycle sustained when neither branch stops (steady count=1, stop=0).
- Upstream hold: while i_data_stop=1, upstream holds; i_data/i_data_valid are ignored.
- Underflow: impossible by construction, since dequeue requires valid.
- Reset (reset=0, any time, including mid-transfer):
  - All pointers and counts go to 0 and queued tokens are discarded.
  - o_data1_valid=0, o_data2_valid=0, i_data_stop=0, o_data1=0, o_data2=0, o_accept_count=0.
  - Deassertion is synchronized externally; the first accept can occur in the first clock after release.

Optional Feature:
- Macro LI_FORK_STATS_EN.
- Defined: o_accept_count increments by 1 on every upstream accept and wraps from 32'hFFFFFFFF to 0. Reset to 0.
- Undefined: o_accept_count tied to 0, and no counter flops exist. Port list is identical in both builds.

Test Plan:
- Streaming: 8 tokens 0x0001..0x0008, valid every cycle, both stops low -> i_data_stop stays 0; each output shows 0x0001..0x0008 in order, one per cycle starting 1 cycle after the first accept.
- One-sided stall: o_data1_stop=1 held, stream 0xA000..0xA003.
  - Branch 2 delivers 0xA000, 0xA001.
  - i_data_stop rises once queue 1 holds DEPTH=2; no further accepts.
  - Release stop1 -> branch 1 delivers 0xA000, 0xA001, then the stream resumes; no loss or duplication on either branch.
- Alternating stops: stop1 and stop2 toggled in opposite phase over 20 random tokens -> scoreboard shows both outputs equal the input sequence; count never exceeds DEPTH.
- Full boundary: both stops high, offer tokens every cycle -> exactly 2 accepted. Drop both stops in the same cycle as a new valid -> the next token is accepted only after i_data_stop falls; order preserved.
- Reset mid-operation: reset low with both queues full (0x0011, 0x0022) -> valids drop immediately (async); after release both valid=0, stop=0. The next token 0x0033 is delivered first.
- With LI_FORK_STATS_EN: 5 accepts -> o_accept_count=5. Preload/force to 32'hFFFFFFFF, one accept -> 0. Without the macro, the port reads 0 throughout.
